diffusion_rmw_scheduler: RTL and testbench
==========================================

Name: diffusion_rmw_scheduler

Overview:
Sequences the Floyd-Steinberg error-diffusion read-modify-write of the four forward neighbours of one pixel over the single-port image SRAM. It is started by the dithering loop controller once a pixel's quantization error is known, and returns a done pulse when all in-bounds neighbours are updated. It computes the neighbour addresses, skips out-of-image neighbours, scales the error by 7/16, 3/16, 5/16 and 1/16, and saturates the result.

Parameters:
IMAGEX, 64, image width in pixels; must be a power of two
IMAGEY, 64, image height in pixels; must be a power of two
RGB_SIZE, 8, pixel component width in bits
IMAGE_ADDR_WIDTH, $clog2(IMAGEX*IMAGEY), SRAM pixel address width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  request to diffuse; sampled only in IDLE
px_idx  in  IMAGE_ADDR_WIDTH  linear index of the current pixel (y*IMAGEX + x); captured on start
q_err  in  RGB_SIZE+1  signed quantization error (old - new); captured on start
busy  out  1  high from the cycle after start is accepted through the FIN cycle inclusive
done  out  1  single-cycle pulse in FIN
sram_addr  out  IMAGE_ADDR_WIDTH  SRAM address
sram_rden  out  1  SRAM read enable
sram_wren  out  1  SRAM write enable
sram_wdata  out  RGB_SIZE  SRAM write data
sram_rdata  in  RGB_SIZE  SRAM read data; valid the cycle after sram_rden

Behaviour:
- Reset (any state): state goes to IDLE; busy, done, sram_rden, sram_wren = 0; sram_addr, sram_wdata = 0; neighbour mask cleared. Any in-flight RMW is abandoned and no write is issued.
- Capture: when start=1 in IDLE, register px_idx and q_err. Derive x = px_idx[log2 IMAGEX-1:0] and y = upper bits.
- Valid-neighbour mask is set at capture:
  - E (idx+1, weight 7): valid if x != IMAGEX-1.
  - SW (idx+IMAGEX-1, weight 3): valid if x != 0 and y != IMAGEY-1.
  - S (idx+IMAGEX, weight 5): valid if y != IMAGEY-1.
  - SE (idx+IMAGEX+1, weight 1): valid if x != IMAGEX-1 and y != IMAGEY-1.
- Processing order is fixed: E, SW, S, SE. Invalid neighbours are skipped with zero cycles spent on them.
- States: IDLE, RD, WR, FIN.
  - IDLE: on start, go to RD for the first valid neighbour; if the mask is empty, go to FIN.
  - RD: one cycle; sram_rden=1, sram_addr = neighbour address. Always go to WR.
  - WR: one cycle; sram_wren=1, same address, sram_wdata = saturated result. Clear that neighbour's mask bit. Go to RD for the next valid neighbour, else FIN.
  - FIN: done=1, busy=1. Go to IDLE.
- Latency: with start accepted at edge k, done is high in cycle k+1+2N, where N = number of valid neighbours (0..4). Range is 1..9 cycles.
- start is ignored while busy. start in FIN is also ignored; a new start is accepted only in IDLE, so back-to-back starts are one cycle apart at minimum.
- Arithmetic:
  - product = q_err * weight, signed, RGB_SIZE+4 bits.
  - contrib = product >>> 4, an arithmetic shift with floor rounding.
  - sum = {0, sram_rdata} + contrib, signed, RGB_SIZE+5 bits.
  - sram_wdata = 0 if sum < 0; 2^RGB_SIZE-1 if sum > 2^RGB_SIZE-1; else sum[RGB_SIZE-1:0].
  - sram_wdata is combinational from sram_rdata during WR and 0 in all other states.
- sram_rden and sram_wren are never high in the same cycle. sram_addr is 0 outside RD/WR.
- Address arithmetic is IMAGE_ADDR_WIDTH bits. Wrap-around cannot occur for valid neighbours, by construction of the mask.

Test Plan:
- Reset mid-WR: assert rst during the WR of E for px_idx=0 -> next cycle busy=0, sram_wren=0, sram_addr=0, state IDLE; no further SRAM activity.
- Top-left corner: px_idx=0, q_err=+16, all rdata=100 -> RD/WR at 1 (wdata 107), then 64 (105), then 65 (101); SW skipped; done at cycle k+7.
- Right edge: px_idx=63, q_err=+32, rdata=10 -> only SW at 126 (wdata 16) and S at 127 (wdata 20); done at k+5. Same bench: px_idx=4043 (y=63, x=11) -> only E at 4044; done at k+3.
- Last pixel: px_idx=4095, any q_err -> no rden/wren; done pulses at k+1; busy high for exactly that one cycle.
- Saturation and rounding: px_idx=0, q_err=-100, E rdata=20 -> contrib -44, wdata 0. q_err=+100, E rdata=250 -> contrib +43, wdata 255. q_err=-1, SE rdata=5 -> contrib -1, wdata 4.
- Start while busy: pulse start with px_idx=5 during the RD of px_idx=0 -> ignored; only the addresses for px_idx=0 are accessed. A start on the cycle after done is accepted.

Source files
------------

// File: rtl/diffusion_rmw_scheduler_if.sv
// Pixel-start handshake plus single-port SRAM bus for the error-diffusion scheduler.
interface diffusion_rmw_scheduler_if #(
    parameter int unsigned RGB_SIZE         = 8,
    parameter int unsigned IMAGE_ADDR_WIDTH = 12
);
    logic                        start;
    logic [IMAGE_ADDR_WIDTH-1:0] px_idx;
    logic [RGB_SIZE:0]           q_err;
    logic                        busy;
    logic                        done;
    logic [IMAGE_ADDR_WIDTH-1:0] sram_addr;
    logic                        sram_rden;
    logic                        sram_wren;
    logic [RGB_SIZE-1:0]         sram_wdata;
    logic [RGB_SIZE-1:0]         sram_rdata;

    // Loop controller / SRAM side
    modport master (
        output start, px_idx, q_err, sram_rdata,
        input  busy, done, sram_addr, sram_rden, sram_wren, sram_wdata
    );

    // Scheduler side
    modport slave (
        input  start, px_idx, q_err, sram_rdata,
        output busy, done, sram_addr, sram_rden, sram_wren, sram_wdata
    );
endinterface

// File: rtl/diffusion_rmw_scheduler.sv
// Floyd-Steinberg read-modify-write sequencer for the four forward neighbours
// (E, SW, S, SE) of one pixel over a single-port image SRAM.
module diffusion_rmw_scheduler #(
    parameter int unsigned IMAGEX           = 64,
    parameter int unsigned IMAGEY           = 64,
    parameter int unsigned RGB_SIZE         = 8,
    parameter int unsigned IMAGE_ADDR_WIDTH = $clog2(IMAGEX * IMAGEY)
) (
    input  logic                      clk,
    input  logic                      rst,
    diffusion_rmw_scheduler_if.slave  bus
);
    localparam int unsigned AW = IMAGE_ADDR_WIDTH;
    localparam int unsigned XW = $clog2(IMAGEX);
    localparam int unsigned YW = AW - XW;
    localparam int unsigned DW = RGB_SIZE;
    localparam int unsigned EW = RGB_SIZE + 1;
    localparam int unsigned PW = RGB_SIZE + 4;
    localparam int unsigned SW = RGB_SIZE + 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t                state_q;
    state_t                state_d;

    logic [AW-1:0]         px_q;
    logic signed [EW-1:0]  err_q;
    // Neighbour mask: [0]=E, [1]=SW, [2]=S, [3]=SE
    logic [3:0]            mask_q;

    logic [XW-1:0]         in_x;
    logic [YW-1:0]         in_y;
    logic                  x_first;
    logic                  x_last;
    logic                  y_last;
    logic [3:0]            cap_mask;

    logic [3:0]            cur_onehot;
    logic [3:0]            mask_rest;
    logic [AW-1:0]         offset;
    logic signed [PW-1:0]  weight;
    logic signed [PW-1:0]  err_ext;
    logic signed [PW-1:0]  product;
    logic signed [PW-1:0]  contrib;
    logic signed [SW-1:0]  sum;
    logic [DW-1:0]         sat;

    logic                  busy_c;
    logic                  done_c;
    logic                  rden_c;
    logic                  wren_c;
    logic [AW-1:0]         addr_c;
    logic [DW-1:0]         wdata_c;

    // Boundary classification of the incoming pixel, used to build the mask at capture
    always_comb begin
        in_x     = bus.px_idx[XW-1:0];
        in_y     = bus.px_idx[AW-1:XW];
        x_first  = (in_x == '0);
        x_last   = (in_x == XW'(IMAGEX - 1));
        y_last   = (in_y == YW'(IMAGEY - 1));
        cap_mask = {~x_last & ~y_last, ~y_last, ~x_first & ~y_last, ~x_last};
    end

    // Current neighbour is the lowest pending mask bit; select its offset and weight
    always_comb begin
        cur_onehot = mask_q & (~mask_q + 4'd1);
        mask_rest  = mask_q & ~cur_onehot;
        offset     = '0;
        weight     = '0;
        case (cur_onehot)
            4'b0001: begin offset = AW'(1);          weight = PW'(7); end
            4'b0010: begin offset = AW'(IMAGEX - 1); weight = PW'(3); end
            4'b0100: begin offset = AW'(IMAGEX);     weight = PW'(5); end
            4'b1000: begin offset = AW'(IMAGEX + 1); weight = PW'(1); end
            default: begin offset = '0;              weight = '0;     end
        endcase
    end

    // Scale the error by weight/16 (floor), add to the read pixel and saturate
    always_comb begin
        err_ext = PW'(err_q);
        product = err_ext * weight;
        contrib = product >>> 4;
        sum     = SW'(signed'({1'b0, bus.sram_rdata})) + SW'(contrib);
        if (sum[SW-1]) begin
            sat = '0;
        end else if (|sum[SW-2:DW]) begin
            sat = '1;
        end else begin
            sat = sum[DW-1:0];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = (|cap_mask) ? S_RD : S_FIN;
                end
            end
            S_RD:    state_d = S_WR;
            S_WR:    state_d = (|mask_rest) ? S_RD : S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Pixel/error capture and per-neighbour mask retirement
    always_ff @(posedge clk) begin
        if (rst) begin
            px_q   <= '0;
            err_q  <= '0;
            mask_q <= '0;
        end else if (state_q == S_IDLE && bus.start) begin
            px_q   <= bus.px_idx;
            err_q  <= bus.q_err;
            mask_q <= cap_mask;
        end else if (state_q == S_WR) begin
            mask_q <= mask_rest;
        end
    end

    // Output decode from the registered state
    always_comb begin
        busy_c  = 1'b0;
        done_c  = 1'b0;
        rden_c  = 1'b0;
        wren_c  = 1'b0;
        addr_c  = '0;
        wdata_c = '0;
        case (state_q)
            S_RD: begin
                busy_c = 1'b1;
                rden_c = 1'b1;
                addr_c = px_q + offset;
            end
            S_WR: begin
                busy_c  = 1'b1;
                wren_c  = 1'b1;
                addr_c  = px_q + offset;
                wdata_c = sat;
            end
            S_FIN: begin
                busy_c = 1'b1;
                done_c = 1'b1;
            end
            default: begin
                busy_c = 1'b0;
            end
        endcase
    end

    assign bus.busy       = busy_c;
    assign bus.done       = done_c;
    assign bus.sram_rden  = rden_c;
    assign bus.sram_wren  = wren_c;
    assign bus.sram_addr  = addr_c;
    assign bus.sram_wdata = wdata_c;

endmodule

// File: tb/tb_diffusion_rmw_scheduler.sv
// Scoreboard bench for diffusion_rmw_scheduler: directed pixels, expected SRAM
// operations queued at launch and checked by an independent monitor.
module tb_diffusion_rmw_scheduler;
    localparam int unsigned AW = 12;
    localparam int unsigned DW = 8;

    typedef struct {
        int kind;   // 0 = read, 1 = write, 2 = done
        int addr;
        int wdata;
        int cyc;
    } op_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    op_t  sb[$];
    op_t  pend[$];
    logic [DW-1:0] mem [0:4095];

    diffusion_rmw_scheduler_if #(.RGB_SIZE(DW), .IMAGE_ADDR_WIDTH(AW)) bus ();

    diffusion_rmw_scheduler #(
        .IMAGEX(64), .IMAGEY(64), .RGB_SIZE(DW), .IMAGE_ADDR_WIDTH(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM read model: data valid the cycle after rden
    always @(posedge clk) begin
        if (bus.sram_rden) bus.sram_rdata <= mem[bus.sram_addr];
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every SRAM access or done pulse must match the head of the scoreboard
    always @(negedge clk) begin : mon
        op_t e;
        int  k;
        if (!rst) begin
            if (bus.sram_rden || bus.sram_wren || bus.done) begin
                chk("rd_wr_overlap", int'(bus.sram_rden & bus.sram_wren), 0);
                if (sb.size() == 0) begin
                    chk("unexpected_activity",
                        int'({bus.done, bus.sram_wren, bus.sram_rden}), 0);
                end else begin
                    e = sb.pop_front();
                    k = bus.done ? 2 : (bus.sram_wren ? 1 : 0);
                    chk("op_kind", k, e.kind);
                    chk("op_cycle", cyc, e.cyc);
                    chk("op_busy", int'(bus.busy), 1);
                    if (e.kind != 2) chk("op_addr", int'(bus.sram_addr), e.addr);
                    if (e.kind == 1) chk("op_wdata", int'(bus.sram_wdata), e.wdata);
                end
            end else begin
                chk("idle_bus", int'({bus.sram_addr, bus.sram_wdata}), 0);
            end
        end
    end

    task automatic fill(input int v);
        for (int i = 0; i < 4096; i++) mem[i] = DW'(v);
    endtask

    task automatic nb(input int a, input int w);
        op_t o;
        o.kind  = 0;
        o.addr  = a;
        o.wdata = w;
        o.cyc   = 0;
        pend.push_back(o);
    endtask

    // Called between a negedge and the following posedge; that posedge accepts start
    task automatic launch(input int idx, input int err);
        int  p;
        op_t o;
        p = cyc + 1;
        foreach (pend[i]) begin
            o      = pend[i];
            o.kind = 0;
            o.cyc  = p + 2 * i;
            sb.push_back(o);
            o.kind = 1;
            o.cyc  = p + 2 * i + 1;
            sb.push_back(o);
        end
        o.kind  = 2;
        o.addr  = 0;
        o.wdata = 0;
        o.cyc   = p + 2 * pend.size();
        sb.push_back(o);
        pend.delete();
        bus.px_idx = AW'(idx);
        bus.q_err  = 9'(err);
        bus.start  = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic finish(input string nm, input bit poke_fin);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (bus.done) seen = 1'b1;
        end
        chk({nm, "_done_seen"}, int'(seen), 1);
        chk({nm, "_sb_empty"}, sb.size(), 0);
        sb.delete();
        if (poke_fin) begin
            bus.start  = 1'b1;
            bus.px_idx = 12'd1;
        end
        @(negedge clk);
        #1 bus.start = 1'b0;
        chk({nm, "_idle_after_done"}, int'(bus.busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.px_idx = '0;
        bus.q_err  = '0;
        fill(100);
        repeat (2) @(negedge clk);
        chk("reset_busy",  int'(bus.busy), 0);
        chk("reset_done",  int'(bus.done), 0);
        chk("reset_rden",  int'(bus.sram_rden), 0);
        chk("reset_wren",  int'(bus.sram_wren), 0);
        chk("reset_addr",  int'(bus.sram_addr), 0);
        chk("reset_wdata", int'(bus.sram_wdata), 0);
        rst = 1'b0;
        #1;

        // Top-left corner: E, S, SE; SW skipped
        fill(100);
        nb(1, 107); nb(64, 105); nb(65, 101);
        launch(0, 16);
        finish("corner", 1'b0);

        // Right edge: SW and S only
        fill(10);
        nb(126, 16); nb(127, 20);
        launch(63, 32);
        finish("right_edge", 1'b0);

        // Bottom row, x=11: E only
        nb(4044, 17);
        launch(4043, 16);
        finish("bottom_row", 1'b0);

        // Last pixel: no accesses; start during FIN is ignored
        launch(4095, -5);
        finish("last_pixel", 1'b1);

        // Negative saturation and floor rounding
        fill(100);
        mem[1] = 8'd20;
        nb(1, 0); nb(64, 68); nb(65, 93);
        launch(0, -100);
        finish("sat_neg", 1'b0);

        // Positive saturation
        fill(100);
        mem[1] = 8'd250;
        nb(1, 255); nb(64, 131); nb(65, 106);
        launch(0, 100);
        finish("sat_pos", 1'b0);

        // q_err = -1 floors to -1 on every weight
        fill(100);
        mem[65] = 8'd5;
        nb(1, 99); nb(64, 99); nb(65, 4);
        launch(0, -1);
        finish("round_neg", 1'b0);

        // Start pulse during RD is ignored
        fill(100);
        nb(1, 107); nb(64, 105); nb(65, 101);
        launch(0, 16);
        @(negedge clk);
        #1;
        bus.start  = 1'b1;
        bus.px_idx = 12'd5;
        bus.q_err  = 9'd50;
        @(posedge clk);
        #1 bus.start = 1'b0;
        finish("start_busy", 1'b0);

        // Reset during the WR of E abandons the RMW
        nb(1, 107); nb(64, 105); nb(65, 101);
        launch(0, 16);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        @(negedge clk);
        #1;
        chk("rst_wr_busy", int'(bus.busy), 0);
        chk("rst_wr_wren", int'(bus.sram_wren), 0);
        chk("rst_wr_rden", int'(bus.sram_rden), 0);
        chk("rst_wr_addr", int'(bus.sram_addr), 0);
        repeat (6) @(negedge clk);
        #1;

        // Fresh pixel after the abandoned one
        nb(1, 107); nb(64, 105); nb(65, 101);
        launch(0, 16);
        finish("after_reset", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
